// File: rtl/mem_fill.sv
// rtl/mem_fill.sv - SDRAM fill engine writing a programmable pattern over an address range in bursts
// Optional feature macro: MEM_FILL_AUTO_START_EN (self-start one whole-space zero fill after reset).
module mem_fill #(
   parameter int ADDR_WIDTH   = 22,
   parameter int DATA_WIDTH   = 32,
   parameter int BURST_LENGTH = 8
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Start,
   input  logic [ADDR_WIDTH-1:0] i_Base_Address,
   input  logic [ADDR_WIDTH-1:0] i_Word_Count,
   input  logic [1:0]            i_Mode,
   input  logic [DATA_WIDTH-1:0] i_Fill_Value,
   input  logic                  i_Data_Write_Done,
   output logic [1:0]            o_Command,
   output logic [ADDR_WIDTH-1:0] o_Data_Address,
   output logic [DATA_WIDTH-1:0] o_Data_Write,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_SDRAM_Initialized
);

   // Command encodings shared with the SDRAM controller.
   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int CW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

   logic [1:0]            state;
   logic [ADDR_WIDTH:0]   remaining;
   logic [ADDR_WIDTH:0]   offset;
   logic [CW-1:0]         countdown;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] value_q;

   logic                  start_go;
   logic [ADDR_WIDTH-1:0] start_base;
   logic [ADDR_WIDTH-1:0] start_count;
   logic [1:0]            start_mode;
   logic [DATA_WIDTH-1:0] start_value;
   logic [ADDR_WIDTH:0]   start_remaining;

   function automatic logic [DATA_WIDTH-1:0] pattern_word(
      input logic [1:0]            mode,
      input logic [DATA_WIDTH-1:0] value,
      input logic [ADDR_WIDTH:0]   off,
      input logic [ADDR_WIDTH-1:0] addr
   );
      logic [ADDR_WIDTH+DATA_WIDTH:0]   off_wide;
      logic [ADDR_WIDTH+DATA_WIDTH-1:0] addr_wide;
      logic [DATA_WIDTH-1:0]            word;
      off_wide  = {{DATA_WIDTH{1'b0}}, off};
      addr_wide = {{DATA_WIDTH{1'b0}}, addr};
      case (mode)
         2'd0:    word = value;
         2'd1:    word = value + off_wide[DATA_WIDTH-1:0];
         2'd2:    word = off[0] ? ~value : value;
         default: word = addr_wide[DATA_WIDTH-1:0];
      endcase
      return word;
   endfunction

   // Countdown reload: words in the coming burst minus one.
   function automatic logic [CW-1:0] burst_countdown(input logic [ADDR_WIDTH:0] rem);
      logic [ADDR_WIDTH:0] bl;
      logic [ADDR_WIDTH:0] size_m1;
      bl      = (ADDR_WIDTH+1)'(BURST_LENGTH);
      size_m1 = ((rem < bl) ? rem : bl) - 1'b1;
      return size_m1[CW-1:0];
   endfunction

`ifdef MEM_FILL_AUTO_START_EN
   logic auto_pending;

   always_comb begin
      start_go    = i_Start || auto_pending;
      start_base  = auto_pending ? '0 : i_Base_Address;
      start_count = auto_pending ? '0 : i_Word_Count;
      start_mode  = auto_pending ? 2'd0 : i_Mode;
      start_value = auto_pending ? '0 : i_Fill_Value;
   end
`else
   always_comb begin
      start_go    = i_Start;
      start_base  = i_Base_Address;
      start_count = i_Word_Count;
      start_mode  = i_Mode;
      start_value = i_Fill_Value;
   end
`endif

   // A zero count means the whole address space, hence the extra remaining bit.
   assign start_remaining = (start_count == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                                : {1'b0, start_count};

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state               <= S_IDLE;
         remaining           <= '0;
         offset              <= '0;
         countdown           <= '0;
         mode_q              <= 2'd0;
         value_q             <= '0;
         o_Data_Address      <= '0;
         o_Data_Write        <= '0;
         o_SDRAM_Initialized <= 1'b0;
`ifdef MEM_FILL_AUTO_START_EN
         auto_pending        <= 1'b1;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start_go) begin
                  mode_q         <= start_mode;
                  value_q        <= start_value;
                  remaining      <= start_remaining;
                  offset         <= '0;
                  countdown      <= burst_countdown(start_remaining);
                  o_Data_Address <= start_base;
                  o_Data_Write   <= pattern_word(start_mode, start_value, '0, start_base);
                  state          <= S_BURST;
`ifdef MEM_FILL_AUTO_START_EN
                  auto_pending   <= 1'b0;
`endif
               end
            end
            S_BURST: begin
               if (i_Data_Write_Done) begin
                  o_Data_Address <= o_Data_Address + 1'b1;
                  offset         <= offset + 1'b1;
                  remaining      <= remaining - 1'b1;
                  o_Data_Write   <= pattern_word(mode_q, value_q, offset + 1'b1,
                                                 o_Data_Address + 1'b1);
                  if (countdown == '0) begin
                     if (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                        state               <= S_DONE;
                        o_SDRAM_Initialized <= 1'b1;
                     end else begin
                        state <= S_GAP;
                     end
                  end else begin
                     countdown <= countdown - 1'b1;
                  end
               end
            end
            S_GAP: begin
               countdown <= burst_countdown(remaining);
               state     <= S_BURST;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_Command = (state == S_BURST) ? CMD_WRITE : CMD_IDLE;
   assign o_Busy    = (state == S_BURST) || (state == S_GAP);
   assign o_Done    = (state == S_DONE);

endmodule

// File: tb/tb_mem_fill.sv
// tb/tb_mem_fill.sv - scoreboard bench for mem_fill
module tb_mem_fill;
`ifdef MEM_FILL_AUTO_START_EN
   localparam int AW = 4;
`else
   localparam int AW = 22;
`endif
   localparam int DW = 32;
   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   logic          i_Clk = 1'b0;
   logic          i_Reset = 1'b1;
   logic          i_Start = 1'b0;
   logic [AW-1:0] i_Base_Address = '0;
   logic [AW-1:0] i_Word_Count = '0;
   logic [1:0]    i_Mode = 2'd0;
   logic [DW-1:0] i_Fill_Value = '0;
   logic          i_Data_Write_Done = 1'b0;
   logic [1:0]    o_Command;
   logic [AW-1:0] o_Data_Address;
   logic [DW-1:0] o_Data_Write;
   logic          o_Busy;
   logic          o_Done;
   logic          o_SDRAM_Initialized;

   mem_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(8)) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start),
      .i_Base_Address(i_Base_Address), .i_Word_Count(i_Word_Count),
      .i_Mode(i_Mode), .i_Fill_Value(i_Fill_Value),
      .i_Data_Write_Done(i_Data_Write_Done), .o_Command(o_Command),
      .o_Data_Address(o_Data_Address), .o_Data_Write(o_Data_Write),
      .o_Busy(o_Busy), .o_Done(o_Done), .o_SDRAM_Initialized(o_SDRAM_Initialized)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   bursts[$];
   int   gaps[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   dmode = 0;
   int   cyc = 0;
   int   burst_words = 0;
   int   gap_cnt = 0;
   bit   in_burst = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   function automatic void push(logic [AW-1:0] a, logic [DW-1:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endfunction

   // Write-done driver: 0 off, 1 every cycle, 2 every other cycle.
   initial forever begin
      @(posedge i_Clk);
      #1;
      cyc++;
      i_Data_Write_Done = (dmode == 1) || (dmode == 2 && cyc[0]);
   end

   // Monitor: every write cycle is compared against the scoreboard head.
   initial forever begin
      @(negedge i_Clk);
      if (!i_Reset) begin
         if (o_Command == CMD_WRITE) begin
            if (gap_cnt > 0) begin
               gaps.push_back(gap_cnt);
               gap_cnt = 0;
            end
            in_burst = 1;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                        o_Data_Address, o_Data_Write);
            end else begin
               check("wr_addr", 64'(o_Data_Address), 64'(exp_q[0].a));
               check("wr_data", 64'(o_Data_Write), 64'(exp_q[0].d));
               if (i_Data_Write_Done) begin
                  void'(exp_q.pop_front());
                  burst_words++;
               end
            end
         end else begin
            if (in_burst) begin
               bursts.push_back(burst_words);
               burst_words = 0;
               in_burst = 0;
            end
            if (o_Busy) gap_cnt++;
         end
      end
   end

   task automatic clear_sb();
      exp_q.delete();
      bursts.delete();
      gaps.delete();
      burst_words = 0;
      gap_cnt = 0;
      in_burst = 0;
   endtask

   task automatic start_fill(logic [AW-1:0] base, logic [AW-1:0] count, logic [1:0] mode,
                             logic [DW-1:0] value, int dm);
      @(posedge i_Clk);
      #2;
      dmode = dm;
      i_Base_Address = base;
      i_Word_Count = count;
      i_Mode = mode;
      i_Fill_Value = value;
      i_Start = 1'b1;
      @(posedge i_Clk);
      #2;
      i_Start = 1'b0;
      check("start_cmd", 64'(o_Command), 64'(CMD_WRITE));
      check("start_busy", 64'(o_Busy), 64'd1);
   endtask

   task automatic wait_done(string name);
      bit seen = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge i_Clk);
         if (o_Done) begin
            seen = 1;
            break;
         end
      end
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_done_cmd"}, 64'(o_Command), 64'(CMD_IDLE));
      check({name, "_init"}, 64'(o_SDRAM_Initialized), 64'd1);
      @(negedge i_Clk);
      check({name, "_done_low"}, 64'(o_Done), 64'd0);
      check({name, "_idle_busy"}, 64'(o_Busy), 64'd0);
      check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      dmode = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge i_Clk);
      #2;
      check("rst_cmd", 64'(o_Command), 64'(CMD_IDLE));
      check("rst_addr", 64'(o_Data_Address), 64'd0);
      check("rst_data", 64'(o_Data_Write), 64'd0);
      check("rst_busy", 64'(o_Busy), 64'd0);
      check("rst_done", 64'(o_Done), 64'd0);
      check("rst_init", 64'(o_SDRAM_Initialized), 64'd0);
`ifdef MEM_FILL_AUTO_START_EN
      for (int i = 0; i < 16; i++) push(AW'(i), 32'h0);
      dmode = 1;
      i_Reset = 1'b0;
      wait_done("auto");
      check("auto_bursts", 64'(bursts.size()), 64'd2);
`else
      i_Reset = 1'b0;
      repeat (3) @(negedge i_Clk);
      check("idle_no_start", 64'(o_Command), 64'(CMD_IDLE));
      check("idle_init", 64'(o_SDRAM_Initialized), 64'd0);

      // Single short burst with increment pattern.
      clear_sb();
      push(22'h10, 32'h100);
      push(22'h11, 32'h101);
      push(22'h12, 32'h102);
      start_fill(22'h10, 22'd3, 2'd1, 32'h100, 1);
      wait_done("t1");
      check("t1_nbursts", 64'(bursts.size()), 64'd1);
      check("t1_burst0", 64'(bursts[0]), 64'd3);

      // Multi-burst fill: 8,8,4 with one idle cycle between bursts.
      clear_sb();
      for (int i = 0; i < 20; i++) push(22'h100 + 22'(i), 32'hDEADBEEF);
      start_fill(22'h100, 22'd20, 2'd0, 32'hDEADBEEF, 1);
      wait_done("t2");
      check("t2_nbursts", 64'(bursts.size()), 64'd3);
      check("t2_burst0", 64'(bursts[0]), 64'd8);
      check("t2_burst1", 64'(bursts[1]), 64'd8);
      check("t2_burst2", 64'(bursts[2]), 64'd4);
      check("t2_ngaps", 64'(gaps.size()), 64'd2);
      check("t2_gap0", 64'(gaps[0]), 64'd1);
      check("t2_gap1", 64'(gaps[1]), 64'd1);

      // Address wrap with address-echo pattern.
      clear_sb();
      push(22'h3FFFFE, 32'h003FFFFE);
      push(22'h3FFFFF, 32'h003FFFFF);
      push(22'h000000, 32'h00000000);
      push(22'h000001, 32'h00000001);
      start_fill(22'h3FFFFE, 22'd4, 2'd3, 32'h12345678, 1);
      wait_done("t3");

      // Checkerboard with a slow controller; address must hold while done is low.
      clear_sb();
      push(22'h40, 32'h0000FFFF);
      push(22'h41, 32'hFFFF0000);
      push(22'h42, 32'h0000FFFF);
      push(22'h43, 32'hFFFF0000);
      start_fill(22'h40, 22'd4, 2'd2, 32'h0000FFFF, 2);
      wait_done("t4");

      // Start during busy is ignored, then reset mid-burst.
      clear_sb();
      for (int i = 0; i < 16; i++) push(22'h200 + 22'(i), 32'(i));
      start_fill(22'h200, 22'd16, 2'd1, 32'h0, 1);
      repeat (3) @(posedge i_Clk);
      #2;
      i_Base_Address = 22'h999;
      i_Mode = 2'd0;
      i_Fill_Value = 32'hAAAA5555;
      i_Word_Count = 22'd1;
      i_Start = 1'b1;
      @(posedge i_Clk);
      #2;
      i_Start = 1'b0;
      repeat (2) @(posedge i_Clk);
      #2;
      check("t5_mid_busy", 64'(o_Busy), 64'd1);
      i_Reset = 1'b1;
      #1;
      check("t5_rst_cmd", 64'(o_Command), 64'(CMD_IDLE));
      check("t5_rst_addr", 64'(o_Data_Address), 64'd0);
      check("t5_rst_data", 64'(o_Data_Write), 64'd0);
      check("t5_rst_busy", 64'(o_Busy), 64'd0);
      check("t5_rst_done", 64'(o_Done), 64'd0);
      check("t5_rst_init", 64'(o_SDRAM_Initialized), 64'd0);
      dmode = 0;
      @(negedge i_Clk);
      #1;
      clear_sb();
      @(posedge i_Clk);
      #2;
      i_Reset = 1'b0;

      // Restart after reset.
      push(22'h5, 32'h77);
      push(22'h6, 32'h77);
      start_fill(22'h5, 22'd2, 2'd0, 32'h77, 1);
      wait_done("t6");
`endif
      repeat (2) @(posedge i_Clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_fill.md
# mem_fill

Parametrised SDRAM fill engine sitting beside the SDRAM controller, driving its command/address/write-data port. Writes a programmable pattern over a programmable address range in controller-sized bursts, with a start/done handshake so it can be re-run at any time (screen clear, test pattern, framebuffer wipe), not only after power-up. Still raises a sticky initialised flag after the first completed fill so downstream readers can gate on it.

## Interface

- `ADDR_WIDTH`, 22, word-address width
- `DATA_WIDTH`, 32, write-data width
- `BURST_LENGTH`, 8, maximum words per `CMD_WRITE` burst (≥1); must match the controller's burst length

- `i_Clk`  in  1  system clock, all logic on rising edge
- `i_Reset`  in  1  asynchronous, active-high reset
- `i_Start`  in  1  start request, sampled only in IDLE
- `i_Base_Address`  in  ADDR_WIDTH  first word address, latched on start
- `i_Word_Count`  in  ADDR_WIDTH  words to write, latched on start; 0 means 2^ADDR_WIDTH (whole space)
- `i_Mode`  in  2  pattern select, latched on start
- `i_Fill_Value`  in  DATA_WIDTH  pattern seed, latched on start
- `i_Data_Write_Done`  in  1  controller accepted current word
- `o_Command`  out  2  `CMD_IDLE`/`CMD_WRITE` from `sdram.vh`
- `o_Data_Address`  out  ADDR_WIDTH  current word address
- `o_Data_Write`  out  DATA_WIDTH  current word data
- `o_Busy`  out  1  fill in progress
- `o_Done`  out  1  one-cycle completion pulse
- `o_SDRAM_Initialized`  out  1  sticky; set on first completed fill

## Operation

- States: IDLE, BURST, GAP, DONE.
- IDLE: `o_Command=CMD_IDLE`. On `i_Start`, latch inputs, remaining := count (0 → 2^ADDR_WIDTH, held in ADDR_WIDTH+1 bits), offset := 0, address := base, go BURST.
- BURST: `o_Command=CMD_WRITE`. Burst size = min(BURST_LENGTH, remaining); countdown loaded with size−1 on entry. Each `i_Data_Write_Done`: address+1 (wraps modulo 2^ADDR_WIDTH), offset+1, remaining−1, data updated to next pattern word. When countdown==0 at a done: remaining now 0 → DONE, else → GAP; otherwise countdown−1.
- GAP: one cycle `CMD_IDLE`, then BURST (reload countdown).
- DONE: `o_Done=1` one cycle, `o_SDRAM_Initialized` set, → IDLE.
- Patterns (offset = words written so far, DATA_WIDTH arithmetic modulo 2^DATA_WIDTH):
  - 0 constant: `i_Fill_Value`
  - 1 increment: `i_Fill_Value + offset`
  - 2 checkerboard: `i_Fill_Value` when offset even, `~i_Fill_Value` when odd
  - 3 address echo: current address zero-extended/truncated to DATA_WIDTH
- `i_Start` in any state other than IDLE is ignored; inputs changing while busy have no effect.
- `o_Busy` = 1 in BURST and GAP, 0 in IDLE and DONE.

## Timing

- Reset (async, any state, including mid-burst): IDLE, `o_Command=CMD_IDLE`, `o_Data_Address=0`, `o_Data_Write=0`, `o_Busy=0`, `o_Done=0`, `o_SDRAM_Initialized=0`.
- Start sampled at edge N → at N+1 `o_Command=CMD_WRITE`, address=base, data=first pattern word, `o_Busy=1`.
- `i_Data_Write_Done` at edge M → next address/data valid after M; one word per done, back-to-back dones allowed.
- Final done at edge M → `CMD_IDLE` and `o_Done=1` after M; `o_Done` low after M+1; new start accepted from M+2.
- Burst boundary: exactly one `CMD_IDLE` cycle between bursts.
- Done asserted while `o_Command=CMD_IDLE` is ignored.

## Configuration

- `MEM_FILL_AUTO_START_EN` defined: after reset release the block self-starts one fill with base 0, count 0 (whole space), mode 0, value 0, ignoring the latched ports for that run; `i_Start` honoured afterwards.
- Undefined: block remains in IDLE until `i_Start`; `o_SDRAM_Initialized` stays 0 until the first requested fill completes.

## Test plan

- Base 0x10, count 3, mode 1, value 0x100, done every cycle → one burst, writes (0x10,0x100),(0x11,0x101),(0x12,0x102), `o_Done` pulse, initialised=1.
- BURST_LENGTH 8, count 20, mode 0, value 0xDEADBEEF → bursts of 8,8,4, single `CMD_IDLE` gap between each, 20 writes total.
- Base 0x3FFFFE, count 4, mode 3 → addresses 0x3FFFFE,0x3FFFFF,0x000000,0x000001 with data equal to address.
- Mode 2, value 0x0000FFFF, count 4, done every other cycle → data 0x0000FFFF,0xFFFF0000,0x0000FFFF,0xFFFF0000; address holds while done low.
- Assert `i_Reset` mid-burst of count 16 → all outputs to reset values immediately; `i_Start` pulsed during busy ignored.
- With `MEM_FILL_AUTO_START_EN`, ADDR_WIDTH 4 → 16 zero writes to 0..15 after reset, `o_SDRAM_Initialized`=1, no start needed.
